lab2_proc_imm_encoder: RTL

//   Inverse of the datapath immediate generator: packs a 32-bit immediate into the

---
 rtl/lab2_proc_imm_pkg.sv | 28 ++
 rtl/lab2_proc_imm_encoder_core.sv | 57 +++++
 rtl/lab2_proc_imm_encoder.sv | 104 ++++++++++
 3 files changed

// File: rtl/lab2_proc_imm_pkg.sv
// Shared immediate-type codes and helpers for the lab2 immediate generator/encoder pair.
`timescale 1ns/1ps
package lab2_proc_imm_pkg;

   typedef enum logic [2:0] {
      IMM_I     = 3'd0,
      IMM_S     = 3'd1,
      IMM_B     = 3'd2,
      IMM_U     = 3'd3,
      IMM_J     = 3'd4,
      IMM_SHAMT = 3'd5
   } imm_type_e;

   typedef struct packed {
      logic [31:0] inst;
      logic        err;
   } enc_entry_t;

   localparam int unsigned QUEUE_DEPTH = 2;

   // True when v[31:lsb] are all copies of the sign bit, i.e. v fits in lsb+1 signed bits.
   function automatic logic all_same(input logic [31:0] v, input int unsigned lsb);
      logic [31:0] sext;
      sext = 32'($signed(v) >>> lsb);
      return (sext == '0) || (sext == '1);
   endfunction

endpackage

// File: rtl/lab2_proc_imm_encoder_core.sv
// Combinational immediate packer: scatters imm bits into the instruction fields of the
// selected type, keeping every other bit of the base instruction.
`timescale 1ns/1ps
module lab2_proc_imm_encoder_core
   import lab2_proc_imm_pkg::*;
(
   input  logic [2:0]  type_i,
   input  logic [31:0] imm_i,
   input  logic [31:0] base_i,
   output logic [31:0] inst_o,
   output logic        err_o
);

   always_comb begin
      inst_o = base_i;
      err_o  = 1'b0;
      case (type_i)
         IMM_I: begin
            inst_o[31:20] = imm_i[11:0];
            err_o         = !all_same(imm_i, 11);
         end
         IMM_S: begin
            inst_o[31:25] = imm_i[11:5];
            inst_o[11:7]  = imm_i[4:0];
            err_o         = !all_same(imm_i, 11);
         end
         IMM_B: begin
            inst_o[31]    = imm_i[12];
            inst_o[30:25] = imm_i[10:5];
            inst_o[11:8]  = imm_i[4:1];
            inst_o[7]     = imm_i[11];
            err_o         = imm_i[0] || !all_same(imm_i, 12);
         end
         IMM_U: begin
            inst_o[31:12] = imm_i[31:12];
            err_o         = (imm_i[11:0] != 12'd0);
         end
         IMM_J: begin
            inst_o[31]    = imm_i[20];
            inst_o[30:21] = imm_i[10:1];
            inst_o[20]    = imm_i[11];
            inst_o[19:12] = imm_i[19:12];
            err_o         = imm_i[0] || !all_same(imm_i, 20);
         end
         IMM_SHAMT: begin
            inst_o[24:20] = imm_i[4:0];
            err_o         = (imm_i[31:5] != 27'd0);
         end
         // Codes 6/7 pass the base through untouched and flag the request.
         default: begin
            inst_o = base_i;
            err_o  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/lab2_proc_imm_encoder.sv
// Registered immediate encoder: val/rdy request, 2-entry output queue whose head drives
// the response, and saturating counters of dequeued and erroneous responses.
`timescale 1ns/1ps
module lab2_proc_imm_encoder
   import lab2_proc_imm_pkg::*;
#(
   parameter int p_cnt_nbits = 16
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_val,
   output logic                   req_rdy,
   input  logic [2:0]             req_type,
   input  logic [31:0]            req_imm,
   input  logic [31:0]            req_base,
   output logic                   resp_val,
   input  logic                   resp_rdy,
   output logic [31:0]            resp_inst,
   output logic                   resp_err,
   output logic [p_cnt_nbits-1:0] num_enc,
   output logic [p_cnt_nbits-1:0] num_err
);

   logic [31:0] enc_inst;
   logic        enc_err;
   enc_entry_t  enc_entry;
   enc_entry_t  head_q, head_d;
   enc_entry_t  tail_q, tail_d;
   logic [1:0]  count_q, count_d;
   logic        enq;
   logic        deq;
   logic [1:0]  cnt_inc;

   lab2_proc_imm_encoder_core u_core (
      .type_i (req_type),
      .imm_i  (req_imm),
      .base_i (req_base),
      .inst_o (enc_inst),
      .err_o  (enc_err)
   );

   assign enc_entry = '{inst: enc_inst, err: enc_err};

   assign req_rdy  = (count_q != 2'(QUEUE_DEPTH));
   assign resp_val = (count_q != 2'd0);
   assign enq      = req_val && req_rdy;
   assign deq      = resp_val && resp_rdy;

   // Head is always the oldest entry; tail only holds data while two entries are queued.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({enq, deq})
         2'b10: begin
            if (count_q == 2'd0) head_d = enc_entry;
            else                 tail_d = enc_entry;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         // Both fire only at count 1, so the new entry replaces the departing head.
         2'b11: head_d = enc_entry;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign resp_inst = head_q.inst;
   assign resp_err  = head_q.err;

   assign cnt_inc = {deq && head_q.err, deq};

   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [p_cnt_nbits-1:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d = cnt_q;
         if (cnt_inc[gi] && (cnt_q != '1)) cnt_d = cnt_q + p_cnt_nbits'(1);
      end

      always_ff @(posedge clk) begin
         if (reset) cnt_q <= '0;
         else       cnt_q <= cnt_d;
      end
   end

   assign num_enc = g_cnt[0].cnt_q;
   assign num_err = g_cnt[1].cnt_q;

endmodule
